// File: rtl/stage_memory.sv
// Memory stage: EX/MEM latch, lw/sw via req/ack data memory,
// overflow redirect to rstatus, one writeback record per instruction.
module stage_memory #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [4:0]        ex_alu_op,
  input  logic [4:0]        ex_rd,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_overflow,
  input  logic              flush,
  output logic              ex_ready,
  output logic              dmem_req,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] FN_ADD  = 5'b00000;
  localparam logic [4:0] FN_SUB  = 5'b00001;
  localparam logic [4:0] RSTATUS = 5'd30;

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        prd_q, prd_d;
  logic              plw_q, plw_d;
  logic              err_q, err_d;
  logic              wbv_q, wbv_d;
  logic              wbwe_q, wbwe_d;
  logic [4:0]        wbrd_q, wbrd_d;
  logic [31:0]       wbdat_q, wbdat_d;

  logic is_alu, is_addi, is_sw, is_lw, is_mem;
  logic ovf_add, ovf_sub, ovf_addi, redirect;
  logic accept, tmo, done;

  logic        rec_we;
  logic [4:0]  rec_rd;
  logic [31:0] rec_data;

  assign is_alu  = ex_opcode == OP_ALU;
  assign is_addi = ex_opcode == OP_ADDI;
  assign is_sw   = ex_opcode == OP_SW;
  assign is_lw   = ex_opcode == OP_LW;
  assign is_mem  = is_sw | is_lw;

  assign ovf_add  = is_alu & (ex_alu_op == FN_ADD)
                  & ex_overflow;
  assign ovf_sub  = is_alu & (ex_alu_op == FN_SUB)
                  & ex_overflow;
  assign ovf_addi = is_addi & ex_overflow;
  assign redirect = ovf_add | ovf_sub | ovf_addi;

  assign accept = ex_valid & ex_ready & ~flush;
  assign tmo    = cnt_q == CW'(TIMEOUT - 1);
  assign done   = dmem_ack | tmo;

  // Writeback record for instructions that retire without memory.
  always_comb begin
    rec_we   = 1'b0;
    rec_rd   = ex_rd;
    rec_data = ex_alu_result;
    unique case (1'b1)
      ovf_add: begin
        rec_we   = 1'b1;
        rec_rd   = RSTATUS;
        rec_data = 32'd1;
      end
      ovf_addi: begin
        rec_we   = 1'b1;
        rec_rd   = RSTATUS;
        rec_data = 32'd2;
      end
      ovf_sub: begin
        rec_we   = 1'b1;
        rec_rd   = RSTATUS;
        rec_data = 32'd3;
      end
      (is_alu | is_addi) & ~redirect: begin
        rec_we = |ex_rd;
      end
      default: rec_we = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      prd_q   <= '0;
      plw_q   <= 1'b0;
      err_q   <= 1'b0;
      wbv_q   <= 1'b0;
      wbwe_q  <= 1'b0;
      wbrd_q  <= '0;
      wbdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      prd_q   <= prd_d;
      plw_q   <= plw_d;
      err_q   <= err_d;
      wbv_q   <= wbv_d;
      wbwe_q  <= wbwe_d;
      wbrd_q  <= wbrd_d;
      wbdat_q <= wbdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:
        if (accept && is_mem) state_d = S_WAIT;
      S_WAIT:
        if (done) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    prd_d   = prd_q;
    plw_d   = plw_q;
    err_d   = err_q;
    wbv_d   = 1'b0;
    wbwe_d  = 1'b0;
    wbrd_d  = '0;
    wbdat_d = '0;
    unique case (state_q)
      S_RUN: begin
        if (accept && is_mem) begin
          req_d   = 1'b1;
          wren_d  = is_sw;
          addr_d  = ex_alu_result[ADDR_W-1:0];
          wdata_d = ex_store_data;
          prd_d   = ex_rd;
          plw_d   = is_lw;
          cnt_d   = '0;
        end else if (accept) begin
          wbv_d   = 1'b1;
          wbwe_d  = rec_we;
          wbrd_d  = rec_rd;
          wbdat_d = rec_data;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          req_d  = 1'b0;
          wbv_d  = 1'b1;
          wbwe_d = plw_q & (|prd_q);
          wbrd_d = prd_q;
          // A timed-out load retires with zero data.
          if (plw_q && dmem_ack) wbdat_d = dmem_rdata;
          if (!dmem_ack) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_ready   = state_q == S_RUN;
    dmem_req   = req_q;
    dmem_wren  = wren_q;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    wb_valid   = wbv_q;
    wb_we      = wbwe_q;
    wb_rd      = wbrd_q;
    wb_data    = wbdat_q;
    mem_error  = err_q;
  end

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory stage of the five-stage pipeline, directly downstream of the execute stage. Registers the execute results (EX/MEM latch), performs `lw`/`sw` accesses to the data memory over a req/ack handshake, and stalls execute while an access is outstanding. Applies the overflow-to-`rstatus` redirect, then presents one writeback record per retired instruction to the writeback stage.

## Interface

Parameters:
- `ADDR_W`, default 12: data-memory word-address width; `dmem_addr` = `ex_alu_result[ADDR_W-1:0]`.
- `TIMEOUT`, default 15: maximum cycles waited for `dmem_ack` before abort.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ex_valid`  in  1  execute presents a valid instruction.
- `ex_opcode`  in  5  instruction opcode.
- `ex_alu_op`  in  5  ALU op field; add=00000, sub=00001.
- `ex_rd`  in  5  destination register.
- `ex_alu_result`  in  32  ALU result; this is the address for `lw`/`sw`.
- `ex_store_data`  in  32  regfile operand B; the `sw` data.
- `ex_overflow`  in  1  ALU overflow.
- `flush`  in  1  kill the instruction offered this cycle.
- `ex_ready`  out  1  stage accepts an instruction this cycle.
- `dmem_req`  out  1  access request.
- `dmem_wren`  out  1  1 = write (`sw`).
- `dmem_addr`  out  ADDR_W  word address.
- `dmem_wdata`  out  32  store data.
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid in the same cycle.
- `dmem_rdata`  in  32  load data.
- `wb_valid`  out  1  writeback record valid (one-cycle pulse per instruction).
- `wb_we`  out  1  register write enable.
- `wb_rd`  out  5  write register.
- `wb_data`  out  32  write data.
- `mem_error`  out  1  sticky; set on timeout, cleared only by reset.

## Operation

- Opcodes:
  - ALU = 00000, `addi` = 00101: write `rd` with the ALU result.
  - `sw` = 00111: memory write, no register write.
  - `lw` = 01000: memory read, write `rd`.
  - All other opcodes: `wb_valid` pulses, `wb_we` = 0.
- Accept condition: `ex_valid & ex_ready & ~flush`. `flush` with `ex_ready` = 0 has no effect.
- FSM states:
  - RUN:
    - `ex_ready` = 1.
    - A non-memory instruction accepted yields a registered writeback record the next cycle.
    - An accepted `lw`/`sw` latches addr/data/wren, raises `dmem_req` the next cycle, and goes to WAIT.
  - WAIT:
    - `ex_ready` = 0 and `dmem_req` = 1; `dmem_addr`, `dmem_wdata` and `dmem_wren` are held stable.
    - A wait counter increments each cycle.
    - On `dmem_ack`: `dmem_req` drops the next cycle and the writeback record is issued that next cycle (`lw` data = `dmem_rdata`). Return to RUN.
    - On the counter reaching TIMEOUT without ack: drop `dmem_req`, set `mem_error`, issue the record with `lw` data = 0, return to RUN.
- Overflow redirect applies to ALU add, ALU sub and `addi` when `ex_overflow` = 1: `wb_rd` = 30, `wb_we` = 1, `wb_data` = 1 (add), 2 (`addi`), 3 (sub). `ex_overflow` is ignored for all other instructions.
- `rd` = 0 forces `wb_we` = 0 unless redirected.
- `flush` never cancels an access already in WAIT.
- Address bits above `ADDR_W` are ignored.

## Timing

- Reset values:
  - `wb_valid`, `wb_we`, `wb_rd`, `wb_data`: 0.
  - `dmem_req`, `dmem_wren`, `dmem_addr`, `dmem_wdata`: 0.
  - `mem_error`: 0.
  - State = RUN, so `ex_ready` = 1 during and after reset.
- Non-memory latency: accept at edge N → `wb_valid` high in cycle N+1, for exactly one cycle.
- Memory latency:
  - Accept at N → `dmem_req` high from N+1.
  - Ack sampled at edge M (M ≥ N+1) → `wb_valid` high and `dmem_req` low in cycle M+1. Earliest `wb_valid` is N+2.
  - `ex_ready` is low from N+1 through M and high again in M+1.
  - Back-to-back acceptance in M+1 is allowed.
- Ack while in RUN is ignored.
- Timeout: no ack through TIMEOUT cycles of WAIT → record in the following cycle, with `mem_error` high from the same cycle.
- Reset asserted mid-WAIT: `dmem_req` drops immediately (async), the record is lost, state = RUN.
- Sustained throughput for non-memory ops: one per cycle.

## Test plan

- Reset with `dmem_ack` stuck 1 → all outputs 0, `ex_ready` = 1. Ack is ignored; no spurious `wb_valid`.
- Back-to-back ALU op (`rd` = 5, result 0x1234) and `addi` (`rd` = 0) → `wb_valid` in two consecutive cycles:
  - first record: `wb_we` = 1, `wb_rd` = 5, `wb_data` = 0x1234;
  - second record: `wb_we` = 0.
- `lw` `rd` = 7, addr 0x00000ABC, ack 3 cycles after req with rdata 0xDEADBEEF:
  - `dmem_addr` = 0xABC held for 3 cycles;
  - `ex_ready` low for 3 cycles;
  - `wb_rd` = 7, `wb_data` = 0xDEADBEEF one cycle after ack.
- `sw` data 0x55 to addr 0x10 with flush asserted during WAIT:
  - `dmem_wren` = 1, `dmem_wdata` = 0x55;
  - access completes normally;
  - record issued with `wb_we` = 0.
- ALU sub with `ex_overflow` = 1, `rd` = 4 → `wb_rd` = 30, `wb_data` = 3, `wb_we` = 1. Repeat for `addi` → `wb_data` = 2.
- `lw` with no ack → after 15 WAIT cycles: `dmem_req` drops, `mem_error` = 1 (sticky), `wb_data` = 0, and the next instruction is accepted.
